uncached_bus_bridge: RTL

UNCACHED_BUS_BRIDGE -- requirements
Module: uncached_bus_bridge

---
 rtl/uncached_bus_bridge_pkg.sv | 66 ++++++
 rtl/cpu_dbus_if.sv | 19 +
 rtl/uncached_wbuf.sv | 48 ++++
 rtl/uncached_bus_bridge.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/uncached_bus_bridge_pkg.sv
// Shared types for the uncached CPU-to-AXI bridge: FSM state enum, AXI
// constants, AXI channel bundles and the posted-write buffer entry.
package uncached_bus_bridge_pkg;

  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_AR  = 3'd1,
    ST_RD_R   = 3'd2,
    ST_WR_AWW = 3'd3,
    ST_WR_B   = 3'd4,
    ST_DONE   = 3'd5
  } unc_state_e;

  // main_st is the CPU-facing FSM, wr_st is whichever FSM owns the AW/W/B channels
  typedef struct packed {
    unc_state_e main_st;
    unc_state_e wr_st;
  } dbg_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wbuf_entry_t;

  typedef struct packed {
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        bready;
  } axi_req_t;

  typedef struct packed {
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        awready;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
  } axi_resp_t;

endpackage

// File: rtl/cpu_dbus_if.sv
// CPU data-bus interface; only the uncached access fields are carried.
interface cpu_dbus_if;
  logic        uncached_read;
  logic        uncached_write;
  logic [31:0] address;
  logic [31:0] wrdata;
  logic [3:0]  byteenable;
  logic        uncached_stall;
  logic [31:0] uncached_rddata;

  modport slave (
    input  uncached_read, uncached_write, address, wrdata, byteenable,
    output uncached_stall, uncached_rddata
  );
  modport master (
    output uncached_read, uncached_write, address, wrdata, byteenable,
    input  uncached_stall, uncached_rddata
  );
endinterface

// File: rtl/uncached_wbuf.sv
// Posted-write FIFO for the uncached bridge; only built when
// UNCACHED_POSTED_WRITE_EN is defined. Head entry stays put until popped.
`ifdef UNCACHED_POSTED_WRITE_EN
module uncached_wbuf
  import uncached_bus_bridge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  wbuf_entry_t push_data,
  input  logic        pop,
  output wbuf_entry_t head,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);

  wbuf_entry_t mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push & ~full};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop & ~empty};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end
endmodule
`endif

// File: rtl/uncached_bus_bridge.sv
// Uncached CPU data-bus to single-beat AXI master bridge.
// Define UNCACHED_POSTED_WRITE_EN to post writes through a WBUF_DEPTH-entry buffer.
module uncached_bus_bridge
  import uncached_bus_bridge_pkg::*;
#(
  parameter int WBUF_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  cpu_dbus_if.slave  dbus,
  output axi_req_t   axi_req,
  input  axi_resp_t  axi_resp,
  output dbg_t       dbg
);
  unc_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rddata_q, rddata_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  unc_state_e  wr_st;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;
  logic        in_aww, aw_hs_done, w_hs_done, aww_exit, b_exit;
  logic        resp_unused;

`ifdef UNCACHED_POSTED_WRITE_EN
  unc_state_e  wst_q, wst_d;
  wbuf_entry_t wbuf_head;
  logic        wbuf_push, wbuf_pop, wbuf_full, wbuf_empty;

  uncached_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wbuf_push),
    .push_data ({dbus.address, dbus.wrdata, dbus.byteenable}),
    .pop       (wbuf_pop),
    .head      (wbuf_head),
    .full      (wbuf_full),
    .empty     (wbuf_empty)
  );

  assign wr_st   = wst_q;
  assign wr_addr = wbuf_head.addr;
  assign wr_data = wbuf_head.data;
  assign wr_strb = wbuf_head.strb;
`else
  localparam int WBUF_DEPTH_UNUSED = WBUF_DEPTH;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;

  assign wr_st   = state_q;
  assign wr_addr = addr_q;
  assign wr_data = wdata_q;
  assign wr_strb = strb_q;
`endif

  // AW and W complete independently; the phase ends once both have handshaken
  assign in_aww     = (wr_st == ST_WR_AWW);
  assign aw_hs_done = aw_done_q | axi_resp.awready;
  assign w_hs_done  = w_done_q | axi_resp.wready;
  assign aww_exit   = in_aww & aw_hs_done & w_hs_done;
  assign b_exit     = (wr_st == ST_WR_B) & axi_resp.bvalid;
  assign resp_unused = ^{axi_resp.rresp, axi_resp.bresp};

  assign dbus.uncached_stall  = (dbus.uncached_read | dbus.uncached_write) & (state_q != ST_DONE);
  assign dbus.uncached_rddata = rddata_q;
  assign dbg = '{main_st: state_q, wr_st: wr_st};

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rddata_d = rddata_q;
`ifdef UNCACHED_POSTED_WRITE_EN
    wbuf_push = 1'b0;
`else
    wdata_d = wdata_q;
    strb_d  = strb_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef UNCACHED_POSTED_WRITE_EN
        if (dbus.uncached_write) begin
          if (!wbuf_full) begin
            wbuf_push = 1'b1;
            state_d   = ST_DONE;
          end
        end else if (dbus.uncached_read && wbuf_empty && (wst_q == ST_IDLE)) begin
          addr_d  = dbus.address;
          state_d = ST_RD_AR;
        end
`else
        if (dbus.uncached_write) begin
          addr_d  = dbus.address;
          wdata_d = dbus.wrdata;
          strb_d  = dbus.byteenable;
          state_d = ST_WR_AWW;
        end else if (dbus.uncached_read) begin
          addr_d  = dbus.address;
          state_d = ST_RD_AR;
        end
`endif
      end
      ST_RD_AR: if (axi_resp.arready) state_d = ST_RD_R;
      ST_RD_R: begin
        if (axi_resp.rvalid && axi_resp.rlast) begin
          rddata_d = axi_resp.rdata;
          state_d  = ST_DONE;
        end
      end
`ifndef UNCACHED_POSTED_WRITE_EN
      ST_WR_AWW: if (aww_exit) state_d = ST_WR_B;
      ST_WR_B:   if (b_exit) state_d = ST_DONE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef UNCACHED_POSTED_WRITE_EN
  // Drain FSM: the head entry is popped only when its B response arrives
  always_comb begin
    wst_d    = wst_q;
    wbuf_pop = 1'b0;
    case (wst_q)
      ST_IDLE:   if (!wbuf_empty) wst_d = ST_WR_AWW;
      ST_WR_AWW: if (aww_exit) wst_d = ST_WR_B;
      ST_WR_B: begin
        if (b_exit) begin
          wbuf_pop = 1'b1;
          wst_d    = ST_IDLE;
        end
      end
      default: wst_d = ST_IDLE;
    endcase
  end
`endif

  always_comb begin
    aw_done_d = 1'b0;
    w_done_d  = 1'b0;
    if (in_aww && !aww_exit) begin
      aw_done_d = aw_hs_done;
      w_done_d  = w_hs_done;
    end
  end

  always_comb begin
    axi_req         = '0;
    axi_req.araddr  = addr_q;
    axi_req.arsize  = SIZE_WORD;
    axi_req.arburst = BURST_INCR;
    axi_req.arvalid = (state_q == ST_RD_AR);
    axi_req.rready  = (state_q == ST_RD_R);
    axi_req.awaddr  = wr_addr;
    axi_req.awsize  = SIZE_WORD;
    axi_req.awburst = BURST_INCR;
    axi_req.awvalid = in_aww & ~aw_done_q;
    axi_req.wdata   = wr_data;
    axi_req.wstrb   = wr_strb;
    axi_req.wlast   = 1'b1;
    axi_req.wvalid  = in_aww & ~w_done_q;
    axi_req.bready  = (wr_st == ST_WR_B);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rddata_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifdef UNCACHED_POSTED_WRITE_EN
      wst_q     <= ST_IDLE;
`else
      wdata_q   <= '0;
      strb_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rddata_q  <= rddata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
`ifdef UNCACHED_POSTED_WRITE_EN
      wst_q     <= wst_d;
`else
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
`endif
    end
  end
endmodule
